// File: rtl/seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_pkg
// Shared constants for the seven-segment scan driver:
//   - SEG_HEX_TABLE : active-low g..a patterns for hex digits 0..F
//   - SEG_OFF       : all segments and dp dark (active-low)
//   - DIGIT_COUNT   : number of multiplexed digits
//   - DIGIT_IDX_W   : width of the digit index
// -----------------------------------------------------------------------------
package seg_scan_driver_pkg;

   localparam int         DIGIT_COUNT = 8;
   localparam int         DIGIT_IDX_W = 3;
   localparam logic [7:0] SEG_OFF     = 8'hFF;

   // Entry n is the pattern for hex digit n; bit 6 = g ... bit 0 = a, 0 = lit.
   // Listed from F down to 0 because a packed array concatenates MSB first.
   localparam logic [15:0][6:0] SEG_HEX_TABLE = {
      7'h0E,  // F
      7'h06,  // E
      7'h21,  // d
      7'h46,  // C
      7'h03,  // b
      7'h08,  // A
      7'h10,  // 9
      7'h00,  // 8
      7'h78,  // 7
      7'h02,  // 6
      7'h12,  // 5
      7'h19,  // 4
      7'h30,  // 3
      7'h24,  // 2
      7'h79,  // 1
      7'h40   // 0
   };

endpackage : seg_scan_driver_pkg

// File: rtl/seg_scan_driver_hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Purely combinational hex nibble to seven-segment decoder (active-low).
// Ports:
//   nibble_i [3:0] : hex digit to display
//   seg_o    [6:0] : segment lines g..a, 0 = segment lit
// -----------------------------------------------------------------------------
module hex_to_seg
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_HEX_TABLE[nibble_i];

endmodule : hex_to_seg

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed eight-digit seven-segment driver for a common-anode board.
// A 32-bit display register is loaded from the address decoder's write strobe
// and its eight nibbles are scanned onto shared segment lines, one digit lit
// for SCAN_DIV clocks at a time. All outputs are registered and active-low.
//
// Parameters:
//   SCAN_DIV : clocks each digit stays lit (>= 1)
// Ports:
//   CLK          : system clock, rising edge
//   RST_N        : asynchronous active-low reset
//   SEG_WE       : one-cycle write strobe
//   SEG_WD[31:0] : write data, nibble i shown on digit i (digit 0 rightmost)
//   AN[7:0]      : digit enables, active-low, one-hot-low while scanning
//   CA[7:0]      : segment lines, active-low, CA[7] = dp, CA[6:0] = g..a
//
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN : when defined, leading-zero digits above
//                               digit 0 are blanked (CA = FF).
// -----------------------------------------------------------------------------
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV = 100000
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SEG_WE,
   input  logic [31:0] SEG_WD,
   output logic [7:0]  AN,
   output logic [7:0]  CA
);

   // A divide-by-one prescaler still needs one (constant-zero) bit.
   localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

   logic [31:0]            disp_q,  disp_d;
   logic [PRESC_W-1:0]     presc_q, presc_d;
   logic [DIGIT_IDX_W-1:0] idx_q,   idx_d;
   logic [7:0]             an_q,    an_d;
   logic [7:0]             ca_q,    ca_d;

   logic                   presc_wrap;
   logic [3:0]             nibble_sel;
   logic [6:0]             seg_g2a;
   logic [DIGIT_COUNT-1:0] blank_mask;

   // Single decoder on whichever nibble the index currently selects.
   hex_to_seg u_hex_to_seg (
      .nibble_i (nibble_sel),
      .seg_o    (seg_g2a)
   );

   // Blanking is derived from the same registered display value as the
   // nibble select, so blank/unblank and new data land on the same edge.
`ifdef SEG_LEADING_ZERO_BLANK_EN
   always_comb begin
      blank_mask = '0;
      // Digit 0 stays lit so a zero value still shows a single "0".
      for (int i = 1; i < DIGIT_COUNT; i++) begin
         blank_mask[i] = ((disp_q >> (4 * i)) == 32'd0);
      end
   end
`else
   assign blank_mask = '0;
`endif

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      disp_d     = disp_q;
      presc_d    = presc_q + 1'b1;
      idx_d      = idx_q;
      presc_wrap = (presc_q == PRESC_LAST);

      if (SEG_WE) begin
         disp_d = SEG_WD;
      end

      // Writes never touch the prescaler or index: the scan keeps its pace.
      if (presc_wrap) begin
         presc_d = '0;
         idx_d   = idx_q + 1'b1;  // 3-bit wrap gives modulo 8 for free
      end

      nibble_sel = 4'(disp_q >> {idx_q, 2'b00});
      an_d       = ~(8'b1 << idx_q);
      ca_d       = blank_mask[idx_q] ? SEG_OFF : {1'b1, seg_g2a};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         disp_q  <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         an_q    <= SEG_OFF;
         ca_q    <= SEG_OFF;
      end else begin
         disp_q  <= disp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         ca_q    <= ca_d;
      end
   end

   assign AN = an_q;
   assign CA = ca_q;

endmodule : seg_scan_driver

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Three driver instances (SCAN_DIV = 4, 2, 1) share clock and reset. A
// reference model derives the expected digit from the number of edges since
// reset and the expected segments from the last value written, then every
// cycle each instance's AN/CA are compared against it.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int NDUT = 3;
   localparam int DIV0 = 4;
   localparam int DIV1 = 2;
   localparam int DIV2 = 1;

   logic        clk;
   logic        rst_n;
   logic        we [NDUT];
   logic [31:0] wd [NDUT];
   logic [7:0]  an [NDUT];
   logic [7:0]  ca [NDUT];

   int          checks   = 0;
   int          failures = 0;

   // Reference state: edges seen since reset release and the value shown.
   int          div_m   [NDUT] = '{DIV0, DIV1, DIV2};
   int          edges_m [NDUT];
   logic [31:0] disp_m  [NDUT];

   logic [7:0]  hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seg_scan_driver #(.SCAN_DIV(DIV0)) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .SEG_WE(we[0]), .SEG_WD(wd[0]), .AN(an[0]), .CA(ca[0]));
   seg_scan_driver #(.SCAN_DIV(DIV1)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .SEG_WE(we[1]), .SEG_WD(wd[1]), .AN(an[1]), .CA(ca[1]));
   seg_scan_driver #(.SCAN_DIV(DIV2)) u_dut2 (
      .CLK(clk), .RST_N(rst_n), .SEG_WE(we[2]), .SEG_WD(wd[2]), .AN(an[2]), .CA(ca[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_ca(input logic [31:0] v, input int idx);
      logic [3:0] nib;
      nib = v[4*idx +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (idx > 0 && (v >> (4 * idx)) == 32'd0) return 8'hFF;
`endif
      return hex_tbl[nib];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         edges_m[k] = 0;
         disp_m[k]  = 32'd0;
      end
   endtask

   task automatic check_all_off(input string tag);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("%s_an%0d", tag, k), an[k], 8'hFF);
         check($sformatf("%s_ca%0d", tag, k), ca[k], 8'hFF);
      end
   endtask

   // One clock: outputs after this edge reflect the digit and value that were
   // current before it; a write sampled at this edge shows one edge later.
   task automatic step();
      int idx;
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         idx = (edges_m[k] / div_m[k]) % 8;
         check($sformatf("an%0d_e%0d", k, edges_m[k]), an[k], ~(8'd1 << idx));
         check($sformatf("ca%0d_e%0d", k, edges_m[k]), ca[k], model_ca(disp_m[k], idx));
         if (we[k]) disp_m[k] = wd[k];
         edges_m[k]++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic write_all(input logic [31:0] v);
      for (int k = 0; k < NDUT; k++) begin
         we[k] = 1'b1;
         wd[k] = v;
      end
      step();
      for (int k = 0; k < NDUT; k++) we[k] = 1'b0;
   endtask

   task automatic write_one(input int k, input logic [31:0] v);
      we[k] = 1'b1;
      wd[k] = v;
      step();
      we[k] = 1'b0;
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         we[k] = 1'b0;
         wd[k] = 32'd0;
      end
      model_reset();

      // Held in reset: everything dark, clock running.
      repeat (3) @(posedge clk);
      #1;
      check_all_off("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Free scan of zero: covers the first-edge FE/C0 and a full wrap at DIV 4.
      idle(40);

      // Full-scan hex pattern check.
      write_all(32'h89AB_CDEF);
      idle(36);

      // Single-digit update on the lit digit of the slow instance.
      write_all(32'd0);
      guard = 0;
      while (((edges_m[0] / DIV0) % 8) != 0 && guard < 64) begin
         step();
         guard++;
      end
      check("align_digit0", (guard < 64) ? 8'd1 : 8'd0, 8'd1);
      write_one(0, 32'h0000_0001);
      idle(6);

      // Back-to-back writes on the divide-by-one instance: last one wins.
      write_one(2, 32'h1111_1111);
      write_one(2, 32'h2222_2222);
      idle(10);

      // Leading-zero pattern (blanked only when the build option is on).
      write_all(32'h0000_0120);
      idle(36);

      // Asynchronous reset while the slow instance is on digit 5.
      write_all(32'hDEAD_BEEF);
      guard = 0;
      while (((edges_m[0] / DIV0) % 8) != 5 && guard < 64) begin
         step();
         guard++;
      end
      check("align_digit5", (guard < 64) ? 8'd1 : 8'd0, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_off("rst_async");
      model_reset();
      @(posedge clk);
      #1;
      check_all_off("rst_edge");
      @(negedge clk);
      rst_n = 1'b1;
      idle(12);

      // Randomized writes, with values shortened so leading zeros are common.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NDUT; k++) begin
            we[k] = ($urandom_range(0, 3) == 0);
            wd[k] = $urandom >> (4 * $urandom_range(0, 8));
         end
         step();
      end
      for (int k = 0; k < NDUT; k++) we[k] = 1'b0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seg_scan_driver
